bram_port_arbiter: RTL

Two-requester round-robin arbiter and sequencer in front of the single-port block-RAM interface. It shares the interface between the PS-facing mailbox side (requester 0) and the PL debugger core (requester 1). It converts valid/ready requests into correctly timed address, enable and data sequences on the interface. It returns read data to the requester that issued the read.

---
 rtl/bram_port_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_arbiter
// Purpose  : Shares one single-port block-RAM interface between two
//            requesters. Requester 0 is the PS-facing mailbox side and
//            requester 1 is the PL debugger core.
//            - Arbitration is round-robin.
//            - Valid/ready requests are turned into correctly timed
//              address / enable / data sequences on the RAM interface.
//            - Read data is returned to the requester that issued the read.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   rising-edge clock
//   reset_n        in   synchronous, active-low reset
//   req_valid[1:0] in   per-requester request strobe
//   req_ready[1:0] out  per-requester accept (combinational, one cycle)
//   req_write[1:0] in   per-requester 1 = write, 0 = read
//   req_addr0/1    in   requester addresses (ADDR_WIDTH+1 bits)
//   req_wdata0/1   in   requester write data
//   rsp_valid[1:0] out  per-requester read-data pulse
//   rsp_rdata      out  shared read-data bus, qualified by rsp_valid
//   busy           out  write sequence running or read in flight
//   write_address  out  RAM address bus
//   read_address   out  RAM address bus (same value as write_address)
//   enable_write   out  RAM write enable
//   enable_read    out  RAM read enable
//   input_data     out  RAM write data
//   output_data    in   RAM read data
// ============================================================================
module bram_port_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_write,
    input  logic [ADDR_WIDTH:0]   req_addr0,
    input  logic [ADDR_WIDTH:0]   req_addr1,
    input  logic [DATA_WIDTH-1:0] req_wdata0,
    input  logic [DATA_WIDTH-1:0] req_wdata1,
    output logic [1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   write_address,
    output logic [ADDR_WIDTH:0]   read_address,
    output logic                  enable_write,
    output logic                  enable_read,
    output logic [DATA_WIDTH-1:0] input_data,
    input  logic [DATA_WIDTH-1:0] output_data
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WR_SETUP  = 2'd1,
        ST_WR_COMMIT = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_last_grant;
    logic [ADDR_WIDTH:0]     r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    // Read tag pipeline: stage READ_LATENCY-1 lines up with valid output_data.
    logic [READ_LATENCY-1:0] r_tag_valid;
    logic [READ_LATENCY-1:0] r_tag_id;
    logic [1:0]              r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;

    logic                    w_idle;
    logic                    w_grant;
    logic                    w_accept;
    logic                    w_grant_write;
    logic [ADDR_WIDTH:0]     w_grant_addr;
    logic [DATA_WIDTH-1:0]   w_grant_wdata;
    logic                    w_rd_issue;
    logic                    w_wr_accept;

    // Arbitration happens only in IDLE. It is gated by reset_n so that
    // nothing is granted in a reset cycle.
    assign w_idle        = reset_n && (r_state == ST_IDLE);
    // On a tie the requester that did not win last time is granted.
    assign w_grant       = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
    assign w_accept      = w_idle && (req_valid != 2'b00);
    assign w_grant_write = w_grant ? req_write[1] : req_write[0];
    assign w_grant_addr  = w_grant ? req_addr1   : req_addr0;
    assign w_grant_wdata = w_grant ? req_wdata1  : req_wdata0;
    assign w_rd_issue    = w_accept && !w_grant_write;
    assign w_wr_accept   = w_accept &&  w_grant_write;

    assign req_ready     = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

    // A read drives the address in its accept cycle, so a read can be issued
    // every cycle. At all other times the bus shows the latched address.
    // During a write this is the write address for both SETUP and COMMIT,
    // and the RAM address register is loaded one cycle before the write
    // enable.
    assign write_address = w_rd_issue ? w_grant_addr : r_addr;
    assign read_address  = write_address;
    assign enable_read   = w_rd_issue;
    assign enable_write  = reset_n && (r_state == ST_WR_COMMIT);
    assign input_data    = r_wdata;

    assign busy          = reset_n && ((r_state != ST_IDLE) || (r_tag_valid != '0));
    assign rsp_valid     = reset_n ? r_rsp_valid : 2'b00;
    assign rsp_rdata     = reset_n ? r_rsp_rdata : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_tag_valid  <= '0;
            r_tag_id     <= '0;
            r_rsp_valid  <= 2'b00;
            r_rsp_rdata  <= '0;
        end else begin
            // The tag pipeline shifts every cycle, independent of the write
            // FSM. This lets in-flight reads drain while a write runs.
            r_tag_valid[0] <= w_rd_issue;
            r_tag_id[0]    <= w_grant;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
                r_tag_id[i]    <= r_tag_id[i-1];
            end

            if (r_tag_valid[READ_LATENCY-1]) begin
                r_rsp_valid <= r_tag_id[READ_LATENCY-1] ? 2'b10 : 2'b01;
                r_rsp_rdata <= output_data;
            end else begin
                r_rsp_valid <= 2'b00;
            end

            if (w_accept) begin
                r_last_grant <= w_grant;
                r_addr       <= w_grant_addr;
            end
            if (w_wr_accept) begin
                r_wdata <= w_grant_wdata;
            end

            case (r_state)
                ST_IDLE:      r_state <= w_wr_accept ? ST_WR_SETUP : ST_IDLE;
                ST_WR_SETUP:  r_state <= ST_WR_COMMIT;
                ST_WR_COMMIT: r_state <= ST_IDLE;
                default:      r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
